// File: rtl/axi_noc_wflit_packer_if.sv
// Signal bundle linking the AW/W FIFO heads, the flit packer and the NoC router port.
// master is the packer side; slave is the FIFO/router side.
interface axi_noc_wflit_packer_if #(
    parameter int DWID  = 32,
    parameter int AWID  = 32,
    parameter int IDWID = 4
) ();
    localparam int SWID     = DWID / 8;
    localparam int WWID     = 1 + SWID + DWID;
    localparam int AWWID    = IDWID + 8 + AWID;
    localparam int PWID_MIN = DWID + SWID + 1;
    // Payload is widened when needed so that a full AW entry always fits in a header flit.
    localparam int PWID     = (PWID_MIN > AWWID) ? PWID_MIN : AWWID;
    localparam int FWID     = PWID + 2;

    logic             aw_empty;
    logic [AWWID-1:0] aw_dout;
    logic             aw_readout;
    logic             w_empty;
    logic [WWID-1:0]  w_dout;
    logic             w_readout;
    logic             flit_vld;
    logic [FWID-1:0]  flit_data;
    logic             flit_last;
    logic             flit_ready;
    logic             busy;
    logic             len_err;

    modport master (
        input  aw_empty, aw_dout, w_empty, w_dout, flit_ready,
        output aw_readout, w_readout, flit_vld, flit_data, flit_last, busy, len_err
    );

    modport slave (
        output aw_empty, aw_dout, w_empty, w_dout, flit_ready,
        input  aw_readout, w_readout, flit_vld, flit_data, flit_last, busy, len_err
    );
endinterface

// File: rtl/axi_noc_wflit_packer.sv
// Packs one AW entry plus its len+1 W beats into a header flit followed by data flits,
// presented on a registered valid/ready stream toward the NoC router.
module axi_noc_wflit_packer #(
    parameter int DWID  = 32,
    parameter int AWID  = 32,
    parameter int IDWID = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   softreset,
    axi_noc_wflit_packer_if.master bus
);
    localparam int SWID     = DWID / 8;
    localparam int WWID     = 1 + SWID + DWID;
    localparam int AWWID    = IDWID + 8 + AWID;
    localparam int PWID_MIN = DWID + SWID + 1;
    localparam int PWID     = (PWID_MIN > AWWID) ? PWID_MIN : AWWID;
    localparam int FWID     = PWID + 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    state_e          state_r;
    state_e          state_nxt_s;
    logic [7:0]      beat_cnt_r;
    logic [7:0]      len_q_r;
    logic            flit_vld_r;
    logic            flit_last_r;
    logic            len_err_r;
    logic [FWID-1:0] flit_data_r;
    logic            slot_free_s;
    logic            aw_pop_s;
    logic            w_pop_s;
    logic            is_last_s;
    logic            wlast_s;

    assign slot_free_s = !flit_vld_r || bus.flit_ready;
    assign is_last_s   = (beat_cnt_r == len_q_r);
    assign wlast_s     = bus.w_dout[WWID-1];

    // Pop decisions and next-state; a pop only happens when the output slot can take the flit.
    always_comb begin
        state_nxt_s = state_r;
        aw_pop_s    = 1'b0;
        w_pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                aw_pop_s = !bus.aw_empty && slot_free_s;
                if (aw_pop_s) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DATA: begin
                w_pop_s = !bus.w_empty && slot_free_s;
                if (w_pop_s && is_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, burst counters and the registered flit output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            beat_cnt_r  <= 8'd0;
            len_q_r     <= 8'd0;
            flit_vld_r  <= 1'b0;
            flit_last_r <= 1'b0;
            flit_data_r <= {FWID{1'b0}};
            len_err_r   <= 1'b0;
        end else if (softreset) begin
            state_r     <= IDLE;
            beat_cnt_r  <= 8'd0;
            len_q_r     <= 8'd0;
            flit_vld_r  <= 1'b0;
            flit_last_r <= 1'b0;
            flit_data_r <= {FWID{1'b0}};
            len_err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (aw_pop_s) begin
                flit_vld_r  <= 1'b1;
                flit_data_r <= {2'b01, PWID'(bus.aw_dout)};
                flit_last_r <= 1'b0;
                len_q_r     <= bus.aw_dout[AWID +: 8];
                beat_cnt_r  <= 8'd0;
            end else if (w_pop_s) begin
                flit_vld_r  <= 1'b1;
                flit_data_r <= {2'b10, PWID'(bus.w_dout)};
                flit_last_r <= is_last_s;
                beat_cnt_r  <= beat_cnt_r + 8'd1;
                // Framing follows len_q; a disagreeing wlast is only flagged.
                if (wlast_s != is_last_s) begin
                    len_err_r <= 1'b1;
                end
            end else if (slot_free_s) begin
                flit_vld_r <= 1'b0;
            end
        end
    end

    assign bus.aw_readout = aw_pop_s;
    assign bus.w_readout  = w_pop_s;
    assign bus.flit_vld   = flit_vld_r;
    assign bus.flit_data  = flit_data_r;
    assign bus.flit_last  = flit_last_r;
    assign bus.busy       = (state_r != IDLE);
    assign bus.len_err    = len_err_r;
endmodule
